// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 16-bit frames into register-bus reads/writes.
// Optional burst addressing is enabled with `define SPI_BRIDGE_AUTOINC_EN.
module spi_reg_bridge #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int WR_HOLD    = 3,
  parameter int RD_HOLD    = 3
) (
  input  logic                  clk_i,
  input  logic                  rstn_n,
  input  logic                  sclk_i,
  input  logic                  cs_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  write_en_o,
  output logic                  read_en_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic                  frame_err_o
);

  localparam int RX_W   = (ADDR_WIDTH > DATA_WIDTH - 1) ? ADDR_WIDTH : DATA_WIDTH - 1;
  localparam int CNT_W  = $clog2(ADDR_WIDTH + DATA_WIDTH);
  localparam int HMAX   = (WR_HOLD > RD_HOLD) ? WR_HOLD : RD_HOLD;
  localparam int HOLD_W = $clog2(HMAX + 1);

  typedef enum logic [2:0] {IDLE, CMD, RD_REQ, DATA, WR_REQ, DONE} state_t;

  state_t                state_reg, state_next;
  logic [2:0]            sclk_sync_reg;
  logic [2:0]            cs_sync_reg;
  logic [1:0]            mosi_sync_reg;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [HOLD_W-1:0]     hold_reg, hold_next;
  logic [RX_W-1:0]       rx_reg, rx_next;
  logic [DATA_WIDTH-1:0] tx_reg, tx_next;
  logic                  rw_reg, rw_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  err_reg, err_next;
  // Set while a burst read beat has been prefetched but no bit of it clocked yet,
  // so ending the burst there is a normal close rather than an abort.
  logic                  quiet_reg, quiet_next;

  logic sclk_rise, sclk_fall, cs_high, cs_fall, mosi_s;

  assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
  assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];
  assign cs_high   = cs_sync_reg[1];
  assign cs_fall   = ~cs_sync_reg[1] & cs_sync_reg[2];
  assign mosi_s    = mosi_sync_reg[1];

  always_ff @(posedge clk_i or negedge rstn_n) begin
    if (!rstn_n) begin
      state_reg     <= IDLE;
      sclk_sync_reg <= '0;
      cs_sync_reg   <= '0;
      mosi_sync_reg <= '0;
      bit_cnt_reg   <= '0;
      hold_reg      <= '0;
      rx_reg        <= '0;
      tx_reg        <= '0;
      rw_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      err_reg       <= 1'b0;
      quiet_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sclk_sync_reg <= {sclk_sync_reg[1:0], sclk_i};
      cs_sync_reg   <= {cs_sync_reg[1:0], cs_n_i};
      mosi_sync_reg <= {mosi_sync_reg[0], mosi_i};
      bit_cnt_reg   <= bit_cnt_next;
      hold_reg      <= hold_next;
      rx_reg        <= rx_next;
      tx_reg        <= tx_next;
      rw_reg        <= rw_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      err_reg       <= err_next;
      quiet_reg     <= quiet_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    hold_next    = hold_reg;
    rx_next      = rx_reg;
    tx_next      = tx_reg;
    rw_next      = rw_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    err_next     = 1'b0;
    quiet_next   = quiet_reg;
    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          bit_cnt_next = '0;
          rx_next      = '0;
          quiet_next   = 1'b0;
          state_next   = CMD;
        end
      end
      CMD: begin
        if (cs_high) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else if (sclk_rise) begin
          rx_next = {rx_reg[RX_W-2:0], mosi_s};
          if (bit_cnt_reg == CNT_W'(ADDR_WIDTH)) begin
            rw_next      = rx_reg[ADDR_WIDTH-1];
            addr_next    = {rx_reg[ADDR_WIDTH-2:0], mosi_s};
            bit_cnt_next = '0;
            hold_next    = '0;
            state_next   = rx_reg[ADDR_WIDTH-1] ? RD_REQ : DATA;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
      end
      RD_REQ: begin
        if (cs_high) begin
          err_next   = ~quiet_reg;
          state_next = IDLE;
        end else if (hold_reg == HOLD_W'(RD_HOLD)) begin
          tx_next      = read_data_i;
          bit_cnt_next = '0;
          state_next   = DATA;
        end else begin
          hold_next = hold_reg + HOLD_W'(1);
        end
      end
      DATA: begin
        if (cs_high) begin
          err_next   = ~(quiet_reg && (bit_cnt_reg == '0));
          state_next = IDLE;
        end else if (sclk_rise) begin
          quiet_next = 1'b0;
          rx_next    = {rx_reg[RX_W-2:0], mosi_s};
          if (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_next = '0;
            if (rw_reg) begin
              state_next = DONE;
            end else begin
              wdata_next = {rx_reg[DATA_WIDTH-2:0], mosi_s};
              hold_next  = '0;
              state_next = WR_REQ;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end else if (sclk_fall && rw_reg && (bit_cnt_reg != '0)) begin
          // The falling edge before the first data rise already has the MSB on the pin.
          tx_next = {tx_reg[DATA_WIDTH-2:0], 1'b0};
        end
      end
      WR_REQ: begin
        if (hold_reg == HOLD_W'(WR_HOLD - 1)) begin
          state_next = DONE;
        end else begin
          hold_next = hold_reg + HOLD_W'(1);
        end
      end
      DONE: begin
        if (cs_high) begin
          state_next = IDLE;
        end
`ifdef SPI_BRIDGE_AUTOINC_EN
        else if (rw_reg && sclk_fall) begin
          // Prefetch the next read beat so its MSB is ready before the next rise.
          addr_next  = addr_reg + ADDR_WIDTH'(1);
          hold_next  = '0;
          quiet_next = 1'b1;
          state_next = RD_REQ;
        end else if (!rw_reg && sclk_rise) begin
          addr_next    = addr_reg + ADDR_WIDTH'(1);
          rx_next      = {rx_reg[RX_W-2:0], mosi_s};
          bit_cnt_next = CNT_W'(1);
          state_next   = DATA;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  assign addr_o       = addr_reg;
  assign write_data_o = wdata_reg;
  assign write_en_o   = (state_reg == WR_REQ);
  assign read_en_o    = (state_reg == RD_REQ) && (hold_reg < HOLD_W'(RD_HOLD));
  assign frame_err_o  = err_reg;
  assign miso_o       = (state_reg == DATA) && rw_reg && !cs_high && tx_reg[DATA_WIDTH-1];

endmodule
